// File: rtl/basic_elements_if.sv
// Side-band signal bundle for the basic_elements primitives (register, latch, bidir controls).
// The bidirectional pin bus itself stays a plain inout on the module.
`timescale 1ns / 1ps

interface basic_elements_if #(
  parameter int unsigned WIDTH = 4
);

  // Register channel
  logic             reg_en;
  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  // Latch channel
  logic             latch_en;
  logic [WIDTH-1:0] latch_d;
  logic [WIDTH-1:0] latch_q;

  // Bidir control/data channel
  logic             bidir_sel_in;
  logic [WIDTH-1:0] bidir_in;
  logic [WIDTH-1:0] bidir_out;

  // Master: the surrounding logic that drives controls and consumes results.
  modport master (
    output reg_en,
    output reg_d,
    input  reg_q,
    output latch_en,
    output latch_d,
    input  latch_q,
    output bidir_sel_in,
    input  bidir_in,
    output bidir_out
  );

  // Slave: the basic_elements block itself.
  modport slave (
    input  reg_en,
    input  reg_d,
    output reg_q,
    input  latch_en,
    input  latch_d,
    output latch_q,
    input  bidir_sel_in,
    output bidir_in,
    input  bidir_out
  );

endinterface

// File: rtl/basic_elements.sv
// Three independent storage/I-O primitives side by side: enabled register with synchronous
// reset, transparent latch, and tri-state bidirectional port.
`timescale 1ns / 1ps

module basic_elements #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  basic_elements_if.slave      bus,
  inout  wire      [WIDTH-1:0] bidir_port
);

  // ---------------------------------------------------------------------------
  // Register: reset wins over enable; otherwise load on enable, else hold.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] reg_q_q;
  logic [WIDTH-1:0] reg_q_d;

  always_comb begin
    reg_q_d = reg_q_q;
    if (reset) begin
      reg_q_d = '0;
    end else if (bus.reg_en) begin
      reg_q_d = bus.reg_d;
    end
  end

  always_ff @(posedge clk) begin
    reg_q_q <= reg_q_d;
  end

  assign bus.reg_q = reg_q_q;

  // ---------------------------------------------------------------------------
  // Latch: transparent while enabled, holds on the falling edge of the enable.
  // Deliberately untouched by clk/reset.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] latch_q;

  always_latch begin
    if (bus.latch_en) begin
      latch_q <= bus.latch_d;
    end
  end

  assign bus.latch_q = latch_q;

  // ---------------------------------------------------------------------------
  // Bidir: release the pins when configured as input; bidir_in always reflects the pins.
  // ---------------------------------------------------------------------------
  assign bidir_port   = bus.bidir_sel_in ? {WIDTH{1'bz}} : bus.bidir_out;
  assign bus.bidir_in = bidir_port;

endmodule

// File: tb/tb_basic_elements.sv
// Randomized scoreboard bench for basic_elements: stimulus pushes expectations, monitors
// pop and compare when the DUT output is due.
`timescale 1ns / 1ps

module tb_basic_elements;

  localparam int unsigned W = 4;

  localparam int KindLatch   = 0;
  localparam int KindBidirIn = 1;
  localparam int KindPort    = 2;

  typedef struct {
    int         kind;
    logic [W-1:0] exp;
  } comb_item_t;

  logic clk;
  logic reset;

  logic         ext_en;
  logic [W-1:0] ext_val;
  wire  [W-1:0] bidir_port;

  basic_elements_if #(.WIDTH(W)) bus ();

  basic_elements #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .bidir_port (bidir_port)
  );

  // External driver on the pin bus
  assign bidir_port = ext_en ? ext_val : {W{1'bz}};

  initial clk = 1'b0;
  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] reg_exp_q[$];
  comb_item_t   comb_q[$];

  // Reference state
  logic [W-1:0] reg_model;
  logic [W-1:0] latch_model;
  bit           latch_known;

  // ---------------------------------------------------------------------------
  // Register stimulus: drive at negedge, expectation is the value after next posedge.
  // ---------------------------------------------------------------------------
  task automatic reg_step(input logic rst, input logic en, input logic [W-1:0] d);
    @(negedge clk);
    reset      = rst;
    bus.reg_en = en;
    bus.reg_d  = d;
    if (rst)     reg_model = '0;
    else if (en) reg_model = d;
    reg_exp_q.push_back(reg_model);
    // Disturb inputs mid-high-phase; must have no effect on the register
    @(posedge clk);
    #0.7;
    bus.reg_d  = W'($urandom);
    bus.reg_en = 1'($urandom);
  endtask

  task automatic reg_stimulus();
    reg_step(1'b1, 1'b0, 4'h0);
    reg_step(1'b0, 1'b1, 4'hA);
    reg_step(1'b1, 1'b1, 4'h5);
    reg_step(1'b0, 1'b1, 4'h5);
    reg_step(1'b0, 1'b0, 4'h3);
    for (int i = 0; i < 150; i++) begin
      reg_step(($urandom_range(0, 9) == 0), 1'($urandom), W'($urandom));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Latch and bidir stimulus: each step settles, pushes expectations, then holds 0.5 ns.
  // ---------------------------------------------------------------------------
  task automatic push_comb(input int kind, input logic [W-1:0] exp);
    comb_item_t it;
    it.kind = kind;
    it.exp  = exp;
    comb_q.push_back(it);
  endtask

  task automatic comb_stimulus();
    bus.latch_en = 1'b1;
    bus.latch_d  = 4'h2;
    latch_model  = 4'h2;
    latch_known  = 1'b1;
    #0.1 push_comb(KindLatch, latch_model);
    #0.5;
    // One change per step so latch_d is stable across every enable edge
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.latch_en = ~bus.latch_en;
      end else begin
        bus.latch_d = W'($urandom);
      end
      if (bus.latch_en) latch_model = bus.latch_d;
      #0.1;
      if (latch_known) push_comb(KindLatch, latch_model);
      #0.5;
    end

    for (int i = 0; i < 60; i++) begin
      logic         sel;
      logic [W-1:0] v;
      sel = 1'($urandom);
      v   = W'($urandom);
      if (sel) begin
        bus.bidir_sel_in = 1'b1;
        ext_val          = v;
        ext_en           = 1'b1;
      end else begin
        ext_en           = 1'b0;
        bus.bidir_out    = v;
        bus.bidir_sel_in = 1'b0;
      end
      #0.1;
      push_comb(KindBidirIn, v);
      push_comb(KindPort, v);
      #0.5;
    end
    ext_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  initial begin : reg_monitor
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #0.5;
      if (reg_exp_q.size() > 0) begin
        exp = reg_exp_q.pop_front();
        checks++;
        if (bus.reg_q !== exp) begin
          errors++;
          $display("FAIL reg_q at %0t: got %h expected %h", $time, bus.reg_q, exp);
        end
      end
    end
  end

  initial begin : comb_monitor
    comb_item_t   it;
    logic [W-1:0] got;
    forever begin
      wait (comb_q.size() > 0);
      #0.2;
      while (comb_q.size() > 0) begin
        it = comb_q.pop_front();
        unique case (it.kind)
          KindLatch:   got = bus.latch_q;
          KindBidirIn: got = bus.bidir_in;
          default:     got = bidir_port;
        endcase
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s at %0t: got %h expected %h",
                   (it.kind == KindLatch) ? "latch_q" :
                   (it.kind == KindBidirIn) ? "bidir_in" : "bidir_port",
                   $time, got, it.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete within 20000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Main
  // ---------------------------------------------------------------------------
  initial begin
    reset            = 1'b1;
    bus.reg_en       = 1'b0;
    bus.reg_d        = '0;
    bus.latch_en     = 1'b0;
    bus.latch_d      = '0;
    bus.bidir_sel_in = 1'b1;
    bus.bidir_out    = '0;
    ext_en           = 1'b0;
    ext_val          = '0;
    reg_model        = '0;
    latch_model      = '0;
    latch_known      = 1'b0;

    fork
      reg_stimulus();
      comb_stimulus();
    join

    #6;
    checks++;
    if (reg_exp_q.size() != 0 || comb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
               reg_exp_q.size(), comb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
